// File: rtl/datapath_unit_pkg.sv
// Shared widths, bus-source priority indices and ALU op indices for the datapath.
package datapath_unit_pkg;
  localparam int DATA_W = 32;
  localparam int Z_W    = 64;

  // Bus sources in priority order: lower index wins.
  localparam int N_BUS_SRC = 24;
  localparam logic [5:0] BUS_HI     = 6'd16;
  localparam logic [5:0] BUS_LO     = 6'd17;
  localparam logic [5:0] BUS_ZHIGH  = 6'd18;
  localparam logic [5:0] BUS_ZLOW   = 6'd19;
  localparam logic [5:0] BUS_PC     = 6'd20;
  localparam logic [5:0] BUS_MDR    = 6'd21;
  localparam logic [5:0] BUS_INPORT = 6'd22;
  localparam logic [5:0] BUS_C      = 6'd23;

  localparam int N_OPS = 14;
  localparam logic [5:0] OP_INCPC = 6'd0;
  localparam logic [5:0] OP_ADD   = 6'd1;
  localparam logic [5:0] OP_SUB   = 6'd2;
  localparam logic [5:0] OP_AND   = 6'd3;
  localparam logic [5:0] OP_OR    = 6'd4;
  localparam logic [5:0] OP_SHR   = 6'd5;
  localparam logic [5:0] OP_SHRA  = 6'd6;
  localparam logic [5:0] OP_SHL   = 6'd7;
  localparam logic [5:0] OP_ROR   = 6'd8;
  localparam logic [5:0] OP_ROL   = 6'd9;
  localparam logic [5:0] OP_NEG   = 6'd10;
  localparam logic [5:0] OP_NOT   = 6'd11;
  localparam logic [5:0] OP_MUL   = 6'd12;
  localparam logic [5:0] OP_DIV   = 6'd13;

  // Index of the lowest set bit; 32 when the vector is empty.
  function automatic logic [5:0] lowest_set(input logic [31:0] v);
    logic [5:0] idx;
    idx = 6'd32;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 6'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A from Y, B from the bus, 64-bit result destined for Z.
module datapath_alu
  import datapath_unit_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [N_OPS-1:0]  op,
  output logic [Z_W-1:0]    result
);
  logic [5:0]        op_idx;
  logic [4:0]        sh;
  logic [Z_W-1:0]    a_sx;
  logic [Z_W-1:0]    b_sx;
  logic [Z_W-1:0]    prod;
  logic [DATA_W-1:0] sra;
  logic [DATA_W-1:0] quot;
  logic [DATA_W-1:0] rem;

  always_comb begin
    op_idx = lowest_set({{(32-N_OPS){1'b0}}, op});
    sh     = b[4:0];
    a_sx   = {{DATA_W{a[DATA_W-1]}}, a};
    b_sx   = {{DATA_W{b[DATA_W-1]}}, b};
    // Low 64 bits of the product of sign-extended operands equal the signed product.
    prod   = a_sx * b_sx;
    sra    = $signed(a) >>> sh;
    if (b == '0) begin
      quot = '1;
      rem  = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      quot = a;
      rem  = '0;
    end else begin
      quot = $signed(a) / $signed(b);
      rem  = $signed(a) % $signed(b);
    end

    result = {32'h0, b};
    case (op_idx)
      OP_INCPC: result = {32'h0, b + 32'd1};
      OP_ADD:   result = {32'h0, a + b};
      OP_SUB:   result = {32'h0, a - b};
      OP_AND:   result = {32'h0, a & b};
      OP_OR:    result = {32'h0, a | b};
      OP_SHR:   result = {32'h0, a >> sh};
      OP_SHRA:  result = {32'h0, sra};
      OP_SHL:   result = {32'h0, a << sh};
      OP_ROR:   result = {32'h0, (a >> sh) | (a << (6'd32 - {1'b0, sh}))};
      OP_ROL:   result = {32'h0, (a << sh) | (a >> (6'd32 - {1'b0, sh}))};
      OP_NEG:   result = {32'h0, 32'd0 - b};
      OP_NOT:   result = {32'h0, ~b};
      OP_MUL:   result = prod;
      OP_DIV:   result = {rem, quot};
      default:  result = {32'h0, b};
    endcase
  end
endmodule

// File: rtl/datapath_unit.sv
// Single-bus datapath: register file, special registers, priority bus mux and ALU.
module datapath_unit
  import datapath_unit_pkg::*;
(
  input  logic clock,
  input  logic clear,
  input  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin,
  input  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
  input  logic IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV,
  input  logic Read,
  input  logic [DATA_W-1:0] Mdatain,
  output logic [DATA_W-1:0] R0, R1, R2, R3, R4, R5, R6, R7,
  output logic [DATA_W-1:0] R8, R9, R10, R11, R12, R13, R14, R15,
  output logic [DATA_W-1:0] HI, LO, PC_out, IR, MAR, Y,
  output logic [Z_W-1:0]    Z,
  output logic [DATA_W-1:0] BusMuxOut_signal
);
  logic [15:0]          r_en;
  logic [N_BUS_SRC-1:0] bus_sel;
  logic [5:0]           bus_src;
  logic [DATA_W-1:0]    bus;
  logic [Z_W-1:0]       alu_res;
  logic [DATA_W-1:0]    r_q [16];
  logic [DATA_W-1:0]    r_d [16];
  logic [DATA_W-1:0]    hi_q, hi_d, lo_q, lo_d, pc_q, pc_d, ir_q, ir_d;
  logic [DATA_W-1:0]    mar_q, mar_d, mdr_q, mdr_d, y_q, y_d;
  logic [Z_W-1:0]       z_q, z_d;

  assign r_en = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign bus_sel = {Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                    R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  always_comb begin
    bus_src = lowest_set({{(32-N_BUS_SRC){1'b0}}, bus_sel});
    bus     = '0;
    if (bus_src < 6'd16) begin
      bus = r_q[bus_src[3:0]];
    end else begin
      case (bus_src)
        BUS_HI:     bus = hi_q;
        BUS_LO:     bus = lo_q;
        BUS_ZHIGH:  bus = z_q[63:32];
        BUS_ZLOW:   bus = z_q[31:0];
        BUS_PC:     bus = pc_q;
        BUS_MDR:    bus = mdr_q;
        BUS_INPORT: bus = '0;
        BUS_C:      bus = {{13{ir_q[18]}}, ir_q[18:0]};
        default:    bus = '0;
      endcase
    end
  end

  datapath_alu u_alu (
    .a      (y_q),
    .b      (bus),
    .op     ({DIV, MUL, NOT, NEG, ROL, ROR, SHL, SHRA, SHR, OR, AND, SUB, ADD, IncPC}),
    .result (alu_res)
  );

  always_comb begin
    for (int i = 0; i < 16; i++) r_d[i] = r_en[i] ? bus : r_q[i];
    hi_d  = HIin  ? bus : hi_q;
    lo_d  = LOin  ? bus : lo_q;
    pc_d  = PCin  ? bus : pc_q;
    ir_d  = IRin  ? bus : ir_q;
    mar_d = MARin ? bus : mar_q;
    y_d   = Yin   ? bus : y_q;
    mdr_d = MDRin ? (Read ? Mdatain : bus) : mdr_q;
    z_d   = Zin   ? alu_res : z_q;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      z_q   <= z_d;
    end
  end

  assign R0  = r_q[0];
  assign R1  = r_q[1];
  assign R2  = r_q[2];
  assign R3  = r_q[3];
  assign R4  = r_q[4];
  assign R5  = r_q[5];
  assign R6  = r_q[6];
  assign R7  = r_q[7];
  assign R8  = r_q[8];
  assign R9  = r_q[9];
  assign R10 = r_q[10];
  assign R11 = r_q[11];
  assign R12 = r_q[12];
  assign R13 = r_q[13];
  assign R14 = r_q[14];
  assign R15 = r_q[15];
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign PC_out = pc_q;
  assign IR     = ir_q;
  assign MAR    = mar_q;
  assign Y      = y_q;
  assign Z      = z_q;
  assign BusMuxOut_signal = bus;
endmodule

// File: tb/tb_datapath_unit.sv
// Directed and randomized checks of datapath_unit against a behavioural ALU/bus model.
module tb_datapath_unit;
  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] rin, rout;
  logic        HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin;
  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout;
  logic [13:0] ops;
  logic        Read;
  logic [31:0] Mdatain;
  logic [31:0] r_obs [16];
  logic [31:0] HI, LO, PC_out, IR, MAR, Y, bus;
  logic [63:0] Z;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  datapath_unit dut (
    .clock(clock), .clear(clear),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .MARin(MARin), .MDRin(MDRin),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout),
    .IncPC(ops[0]), .ADD(ops[1]), .SUB(ops[2]), .AND(ops[3]), .OR(ops[4]),
    .SHR(ops[5]), .SHRA(ops[6]), .SHL(ops[7]), .ROR(ops[8]), .ROL(ops[9]),
    .NEG(ops[10]), .NOT(ops[11]), .MUL(ops[12]), .DIV(ops[13]),
    .Read(Read), .Mdatain(Mdatain),
    .R0(r_obs[0]), .R1(r_obs[1]), .R2(r_obs[2]), .R3(r_obs[3]),
    .R4(r_obs[4]), .R5(r_obs[5]), .R6(r_obs[6]), .R7(r_obs[7]),
    .R8(r_obs[8]), .R9(r_obs[9]), .R10(r_obs[10]), .R11(r_obs[11]),
    .R12(r_obs[12]), .R13(r_obs[13]), .R14(r_obs[14]), .R15(r_obs[15]),
    .HI(HI), .LO(LO), .PC_out(PC_out), .IR(IR), .MAR(MAR), .Y(Y),
    .Z(Z), .BusMuxOut_signal(bus)
  );

  // Reference ALU written from the arithmetic definitions, using 64-bit signed math.
  function automatic logic [63:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    int          ia, ib, sh;
    longint      la, lb, q, r, p;
    logic [31:0] t;
    ia = a; ib = b; la = ia; lb = ib;
    sh = int'(b % 32);
    t  = a;
    case (op)
      0:  return {32'h0, b + 32'd1};
      1:  return {32'h0, a + b};
      2:  return {32'h0, a - b};
      3:  return {32'h0, a & b};
      4:  return {32'h0, a | b};
      5:  return {32'h0, a >> sh};
      6:  begin p = la >>> sh; return {32'h0, p[31:0]}; end
      7:  return {32'h0, a << sh};
      8:  begin repeat (sh) t = {t[0], t[31:1]}; return {32'h0, t}; end
      9:  begin repeat (sh) t = {t[30:0], t[31]}; return {32'h0, t}; end
      10: return {32'h0, 32'd0 - b};
      11: return {32'h0, ~b};
      12: begin p = la * lb; return p; end
      13: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
      end
      default: return {32'h0, b};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rin = '0; rout = '0; ops = '0;
    {HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin} = '0;
    {HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout} = '0;
    Read = 1'b0; Mdatain = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic mem_to_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick();
  endtask

  task automatic load_gpr(input int idx, input logic [31:0] v);
    mem_to_mdr(v);
    MDRout = 1'b1; rin[idx] = 1'b1;
    tick();
  endtask

  task automatic load_y(input logic [31:0] v);
    mem_to_mdr(v);
    MDRout = 1'b1; Yin = 1'b1;
    tick();
  endtask

  // Y=a, bus=b (via MDR), strobe up to two ops, latch Z and compare.
  task automatic run_op(input string tag, input int opi, input int opj,
                        input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    load_y(a);
    mem_to_mdr(b);
    MDRout = 1'b1; Zin = 1'b1;
    ops = (14'd1 << opi) | (14'd1 << opj);
    tick();
    chk(tag, Z, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b, instr;
    int          opi, opj;

    idle();
    clear = 1'b1;
    tick(); tick();
    clear = 1'b0;
    chk("rst_r0", r_obs[0], 0);
    chk("rst_r15", r_obs[15], 0);
    chk("rst_pc", PC_out, 0);
    chk("rst_z", Z, 0);
    chk("bus_idle", bus, 0);

    // SHRA program sequence with a fetch in between
    load_gpr(0, 32'hF000_0000);
    load_gpr(4, 32'd4);
    chk("load_r0", r_obs[0], 64'hF000_0000);
    instr = 32'h1234_5678;
    PCout = 1'b1; MARin = 1'b1; ops[0] = 1'b1; Zin = 1'b1;
    tick();
    Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = instr;
    tick();
    MDRout = 1'b1; IRin = 1'b1;
    tick();
    chk("fetch_pc", PC_out, 1);
    chk("fetch_mar", MAR, 0);
    chk("fetch_ir", IR, instr);
    rout[0] = 1'b1; Yin = 1'b1;
    tick();
    rout[4] = 1'b1; ops[6] = 1'b1; Zin = 1'b1;
    tick();
    Zlowout = 1'b1; rin[7] = 1'b1;
    tick();
    chk("shra_r7", r_obs[7], 64'hFF00_0000);
    chk("shra_pc", PC_out, 1);

    Cout = 1'b1; #1;
    chk("bus_cout", bus, 64'hFFFC_5678);
    idle(); InPortout = 1'b1; #1;
    chk("bus_inport", bus, 0);
    idle();

    run_op("shr", 5, 14, 32'hF000_0000, 32'd4, 64'h0F00_0000);
    run_op("shl", 7, 14, 32'hF000_0000, 32'd4, 64'h0000_0000);
    run_op("ror", 8, 14, 32'hF000_0000, 32'd4, 64'h0F00_0000);
    run_op("rol", 9, 14, 32'hF000_0000, 32'd4, 64'h0000_000F);
    run_op("rol_36", 9, 14, 32'hF000_0000, 32'd36, 64'h0000_000F);
    run_op("shra_0", 6, 14, 32'h8123_4567, 32'd0, 64'h8123_4567);
    run_op("add", 1, 14, 32'h7FFF_FFFF, 32'd1, 64'h0000_0000_8000_0000);
    run_op("mul", 12, 14, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    Zhighout = 1'b1; HIin = 1'b1;
    tick();
    Zlowout = 1'b1; LOin = 1'b1;
    tick();
    chk("mul_hi", HI, 64'hFFFF_FFFF);
    chk("mul_lo", LO, 64'hFFFF_FFF1);
    run_op("div_neg", 13, 14, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_zero", 13, 14, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF);
    run_op("add_beats_mul", 1, 12, 32'd6, 32'd7, 64'd13);
    run_op("no_op", 14, 14, 32'd6, 32'hABCD_0123, 64'hABCD_0123);
    run_op("sub", 2, 14, 32'd5, 32'd7, 64'h0000_0000_FFFF_FFFE);

    // Z written while Zlow drives the bus: bus and ALU see the old Z
    load_y(32'd3);
    Zlowout = 1'b1; ops[1] = 1'b1; Zin = 1'b1; #1;
    chk("zlow_old_bus", bus, 64'hFFFF_FFFE);
    tick();
    chk("zlow_new_z", Z, 64'h0000_0000_0000_0001);

    // Bus priority: R0 beats MDR
    load_gpr(0, 32'h1111_2222);
    mem_to_mdr(32'h3333_4444);
    MDRout = 1'b1; rout[0] = 1'b1; #1;
    chk("prio_r0_mdr", bus, 64'h1111_2222);
    idle(); Zhighout = 1'b1; Cout = 1'b1; #1;
    chk("prio_zhigh_c", bus, 0);
    idle(); #1;
    chk("bus_idle2", bus, 0);

    for (int k = 0; k < 60; k++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b % 64;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      opi = $urandom_range(0, 14);
      opj = $urandom_range(opi, 14);
      run_op($sformatf("rand%0d_op%0d", k, opi), opi, opj, a, b, alu_ref(opi, a, b));
    end

    // Clear overrides every enable
    load_gpr(5, 32'h5555_AAAA);
    clear = 1'b1; rin = '1; Read = 1'b1; Mdatain = 32'hDEAD_BEEF;
    {HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin} = '1;
    MDRout = 1'b1; ops[1] = 1'b1;
    @(posedge clock); #1;
    idle(); clear = 1'b0;
    for (int i = 0; i < 16; i++) chk($sformatf("clr_r%0d", i), r_obs[i], 0);
    chk("clr_hi", HI, 0);
    chk("clr_lo", LO, 0);
    chk("clr_pc", PC_out, 0);
    chk("clr_ir", IR, 0);
    chk("clr_mar", MAR, 0);
    chk("clr_y", Y, 0);
    chk("clr_z", Z, 0);
    MDRout = 1'b1; #1;
    chk("clr_mdr", bus, 0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/datapath_unit.md
Name: datapath_unit

Overview:
- 32-bit single-bus CPU datapath: 16 GPRs, HI, LO, PC, IR, MAR, MDR, Y and a 64-bit Z register around one shared bus, plus a combinational ALU.
- All sequencing comes from external one-hot control strobes (testbench or control unit); the block holds no FSM.
- Sits under the control unit; external memory data enters through Mdatain.

Parameters:
- none (widths fixed: data 32, Z 64)

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  reset: synchronous, active-high; zeroes every register
- R0in..R15in, HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin  in  1 each  register load enables
- R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout  in  1 each  bus source selects
- IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV  in  1 each  ALU op selects
- Read  in  1  MDR input mux: 1 = Mdatain, 0 = bus
- Mdatain  in  32  memory read data
- R0..R15, HI, LO, PC_out, IR, MAR, Y  out  32 each  register contents
- Z  out  64  Z register {Zhigh, Zlow}
- BusMuxOut_signal  out  32  current bus value

Behaviour:
- Registers
  - All registers update only on posedge clock.
  - clear=1 zeroes every register and overrides all enables.
  - Otherwise a register loads when its *in is high; it holds when low.
  - Every output register resets to 0.
- Register sources
  - GPRs, HI, LO, PC, IR, MAR, Y load from the bus. R0 is an ordinary register.
  - MDR loads Read ? Mdatain : bus.
  - Z loads the 64-bit ALU result.
- Bus mux (combinational)
  - Selects drive R0..R15, HI, LO, Z[63:32], Z[31:0], PC, MDR.
  - InPortout drives 32'h0 (no input port in this block).
  - Cout drives IR[18:0] sign-extended to 32 bits.
  - No select active: bus = 0.
  - Multiple selects active: lowest in listed order wins (R0 highest priority, Cout lowest).
- ALU (combinational)
  - Operands: A = Y, B = bus.
  - Result is 64 bits; 32-bit results are zero-extended into Z.
  - Ops, if several active the first listed wins:
    - IncPC: B+1
    - ADD: A+B
    - SUB: A-B
    - AND: A&B
    - OR: A|B
    - SHR: A>>B[4:0], logical
    - SHRA: A>>>B[4:0], arithmetic, sign-filled
    - SHL: A<<B[4:0]
    - ROR / ROL: rotate A by B[4:0]
    - NEG: -B (two's complement)
    - NOT: ~B
    - MUL: signed A*B, full 64 bits
    - DIV: signed; Z[31:0] = quotient truncated toward zero, Z[63:32] = remainder with the dividend's sign
    - no op: {32'h0, B}
  - Shift/rotate amount 0 returns A unchanged; amounts above 31 use the low 5 bits only.
  - DIV by zero: quotient = 32'hFFFFFFFF, remainder = A.
  - Overflow wraps silently; no flags.
- Latency
  - Bus and ALU are combinational within the cycle.
  - A register written at edge N is visible on the bus in cycle N+1.
- Simultaneous events
  - Register write and bus read of the same register in one cycle: the bus shows the old value.
  - Writing Z and driving Zlowout in the same cycle: the bus shows the old Z.

Decomposition:
- Shared package:
  - localparam DATA_W = 32
  - bus-select priority order
  - ALU op encoding for the internal one-hot-to-index conversion
- One natural sub-module, datapath_alu: A, B, op strobes in; 64-bit result out.
- Registers and bus mux stay in the top level.

Test Plan:
- SHRA sequence:
  - Load R0 = 0xF0000000 and R4 = 4 via Mdatain→MDR→bus.
  - Run the fetch T0–T2 (PC=0→1; IR gets Mdatain).
  - R0out,Yin; then R4out,SHRA,Zin; then Zlowout,R7in.
  - Required: R7 = 0xFF000000, PC_out = 1.
- SHR/SHL/ROR/ROL, same Y = 0xF0000000 and amount 4 → 0x0F000000 / 0x00000000 / 0x0F000000 / 0x0000000F.
- ADD Y = 0x7FFFFFFF, B = 1 → Z = 0x0000000080000000.
- SUB 5−7 → Zlow = 0xFFFFFFFE.
- MUL −3 × 5 → Z = 0xFFFFFFFFFFFFFFF1 (HI/LO loaded via Zhighout/Zlowout).
- DIV −7/2 → Zlow = 0xFFFFFFFD, Zhigh = 0xFFFFFFFF.
- DIV 9/0 → Zlow = 0xFFFFFFFF, Zhigh = 9.
- clear asserted after nonzero loads → every register 0 on the next edge, even with enables high.
- Bus idle (no select) → BusMuxOut_signal = 0.
- Bus with MDRout and R0out both high → bus carries R0.
